// File: rtl/computation_pkg.sv
// ============================================================================
// Module      : computation_pkg
// Description : Types and constants shared by the computation datapath:
//               the price receiver FSM state encoding, the default frame
//               sync marker, and the price word width that is also used by
//               computation_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package computation_pkg;

    localparam int        PRICE_W           = 32;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Receiver FSM states. ST_CHK is only reachable when the checksum
    // option is built in.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_B3   = 4'd1,
        ST_B2   = 4'd2,
        ST_B1   = 4'd3,
        ST_B0   = 4'd4,
        ST_CHK  = 4'd5,
        ST_EMIT = 4'd6
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_timeout_counter.sv
// ============================================================================
// Module      : rx_timeout_counter
// Description : Idle-cycle counter for the price receiver. Counts cycles
//               with count_en high, returns to zero on clear (clear wins).
//               expired is high while the current cycle is the
//               TIMEOUT_CYCLES-th consecutive counted cycle, so the owner
//               can abort in that same cycle if no byte shows up.
// Ports       : clk, n_rst (async, active-low), clear, count_en -> expired
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // The counter holds the number of idle cycles already completed, so
    // the current cycle is the last allowed one when it reads TIMEOUT-1.
    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/price_receiver.sv
// ============================================================================
// Module      : price_receiver
// Description : Assembles framed byte-stream stock prices (sync byte followed
//               by four big-endian price bytes) into a 32-bit word.
//               Incomplete or stalled frames are dropped and flagged.
// Options     : PRICE_RX_CHECKSUM_EN - frame carries a fifth byte, the XOR of
//               the four price bytes; a mismatch drops the frame.
// Ports       : clk, n_rst (async, active-low)
//               rx_byte[7:0], rx_valid          - input byte stream
//               stock_price[31:0]               - last good price (held)
//               data_ready                      - 1-cycle new-price pulse
//               frame_error                     - 1-cycle abort pulse
//               busy                            - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module price_receiver
    import computation_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    output logic [PRICE_W-1:0] stock_price,
    output logic               data_ready,
    output logic               frame_error,
    output logic               busy
);

    rx_state_t state;

`ifdef PRICE_RX_CHECKSUM_EN
    logic [PRICE_W-1:0] shadow;
    logic [7:0]         csum;
`else
    // The low byte goes straight into stock_price, so it is never stored.
    logic [PRICE_W-1:8] shadow;
`endif

    logic in_frame;
    logic cnt_en;
    logic cnt_clear;
    logic expired;
    logic timeout_abort;

    // Only the byte-collecting states are subject to the idle timeout.
    assign in_frame      = (state != ST_IDLE) && (state != ST_EMIT);
    assign cnt_en        = in_frame && !rx_valid;
    assign cnt_clear     = !in_frame || rx_valid;
    // A byte arriving on the expiry cycle is accepted, hence !rx_valid.
    assign timeout_abort = cnt_en && expired;

    rx_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clear),
        .count_en (cnt_en),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            stock_price <= '0;
            data_ready  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
`ifdef PRICE_RX_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            data_ready  <= 1'b0;
            frame_error <= 1'b0;

            if (timeout_abort) begin
                state       <= ST_IDLE;
                frame_error <= 1'b1;
                busy        <= 1'b0;
            end else begin
                case (state)
                    // EMIT treats its byte like IDLE so frames can abut.
                    ST_IDLE, ST_EMIT: begin
                        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                            state <= ST_B3;
                            busy  <= 1'b1;
`ifdef PRICE_RX_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    ST_B3: if (rx_valid) begin
                        shadow[31:24] <= rx_byte;
                        state         <= ST_B2;
`ifdef PRICE_RX_CHECKSUM_EN
                        csum          <= csum ^ rx_byte;
`endif
                    end

                    ST_B2: if (rx_valid) begin
                        shadow[23:16] <= rx_byte;
                        state         <= ST_B1;
`ifdef PRICE_RX_CHECKSUM_EN
                        csum          <= csum ^ rx_byte;
`endif
                    end

                    ST_B1: if (rx_valid) begin
                        shadow[15:8] <= rx_byte;
                        state        <= ST_B0;
`ifdef PRICE_RX_CHECKSUM_EN
                        csum         <= csum ^ rx_byte;
`endif
                    end

                    ST_B0: if (rx_valid) begin
`ifdef PRICE_RX_CHECKSUM_EN
                        shadow[7:0] <= rx_byte;
                        csum        <= csum ^ rx_byte;
                        state       <= ST_CHK;
`else
                        stock_price <= {shadow[31:8], rx_byte};
                        data_ready  <= 1'b1;
                        state       <= ST_EMIT;
`endif
                    end

`ifdef PRICE_RX_CHECKSUM_EN
                    ST_CHK: if (rx_valid) begin
                        if (rx_byte == csum) begin
                            stock_price <= shadow;
                            data_ready  <= 1'b1;
                            state       <= ST_EMIT;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                        end
                    end
`endif

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_price_receiver.sv
// ============================================================================
// Module      : tb_price_receiver
// Description : Self-checking bench for price_receiver (TIMEOUT_CYCLES = 4).
//               Expected pulses are queued as stimulus is issued; a monitor
//               pops and compares on every data_ready / frame_error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_price_receiver;
    import computation_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [31:0] stock_price;
    logic        data_ready;
    logic        frame_error;
    logic        busy;

    typedef struct packed {
        logic        err;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int          tests;
    int          fails;
    logic [31:0] last_price;

    always #5 clk = ~clk;

    price_receiver #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .stock_price (stock_price),
        .data_ready  (data_ready),
        .frame_error (frame_error),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b3, input logic [7:0] b2,
                              input logic [7:0] b1, input logic [7:0] b0);
        send(8'hA5);
        send(b3);
        send(b2);
        send(b1);
        send(b0);
`ifdef PRICE_RX_CHECKSUM_EN
        send(b3 ^ b2 ^ b1 ^ b0);
`endif
    endtask

    task automatic expect_price(input logic [31:0] v);
        q.push_back('{err: 1'b0, val: v});
        last_price = v;
    endtask

    task automatic expect_error();
        q.push_back('{err: 1'b1, val: last_price});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests      = 0;
        fails      = 0;
        last_price = '0;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        n_rst      = 1'b0;

        #12;
        check("reset_price", stock_price, 32'h0);
        check("reset_ready", {31'b0, data_ready}, 32'h0);
        check("reset_error", {31'b0, frame_error}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        fork
            forever begin
                @(negedge clk);
                if (data_ready || frame_error) begin
                    check("pulse_exclusive", {31'b0, data_ready & frame_error}, 32'h0);
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pulse: ready=%b error=%b price=%h",
                                 data_ready, frame_error, stock_price);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("pulse_kind_is_error", {31'b0, frame_error}, {31'b0, e.err});
                        check("pulse_price", stock_price, e.val);
                    end
                end
            end
        join_none

        // Good frame, with latency and busy checks
        expect_price(32'h12345678);
        send(8'hA5);
        check("busy_after_sync", {31'b0, busy}, 32'h1);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
`ifdef PRICE_RX_CHECKSUM_EN
        send(8'h08);
`endif
        check("ready_latency", {31'b0, data_ready}, 32'h1);
        check("price_at_ready", stock_price, 32'h12345678);
        idle(2);
        check("busy_after_frame", {31'b0, busy}, 32'h0);
        check("ready_one_cycle", {31'b0, data_ready}, 32'h0);

        // Garbage in IDLE, then back-to-back frames
        expect_price(32'h00000001);
        expect_price(32'h00000002);
        send(8'h00);
        send(8'hFF);
        check("garbage_not_busy", {31'b0, busy}, 32'h0);
        send_frame(8'h00, 8'h00, 8'h00, 8'h01);
        send_frame(8'h00, 8'h00, 8'h00, 8'h02);
        idle(2);

        // Sync value as data
        expect_price(32'hA5A5A5A5);
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5);
        idle(2);
        check("sync_as_data", stock_price, 32'hA5A5A5A5);

        // Timeout abort after four idle cycles
        expect_error();
        send(8'hA5);
        send(8'h11);
        idle(4);
        check("timeout_error", {31'b0, frame_error}, 32'h1);
        check("timeout_busy", {31'b0, busy}, 32'h0);
        check("timeout_price_held", stock_price, 32'hA5A5A5A5);
        idle(2);

        // Byte on the expiry cycle wins
        expect_price(32'h11223344);
        send(8'hA5);
        send(8'h11);
        idle(3);
        send(8'h22);
        send(8'h33);
        send(8'h44);
`ifdef PRICE_RX_CHECKSUM_EN
        send(8'h44);
`endif
        check("expiry_byte_ready", {31'b0, data_ready}, 32'h1);
        idle(10);

`ifdef PRICE_RX_CHECKSUM_EN
        // Checksum mismatch
        expect_error();
        send(8'hA5);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        send(8'h09);
        check("csum_error", {31'b0, frame_error}, 32'h1);
        check("csum_no_ready", {31'b0, data_ready}, 32'h0);
        check("csum_price_held", stock_price, 32'h11223344);
        idle(2);
`endif

        // Asynchronous reset in the middle of a frame
        send(8'hA5);
        send(8'h12);
        #2;
        n_rst = 1'b0;
        #1;
        check("midreset_price", stock_price, 32'h0);
        check("midreset_busy", {31'b0, busy}, 32'h0);
        check("midreset_ready", {31'b0, data_ready}, 32'h0);
        check("midreset_error", {31'b0, frame_error}, 32'h0);
        last_price = '0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        expect_price(32'hDEADBEEF);
        send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        idle(3);
        check("queue_drained", 32'(q.size()), 32'h0);
        check("final_price", stock_price, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/price_receiver.md
# price_receiver

Upstream front end of the computation datapath. Accepts a byte-wide stream of framed stock-price records. Each frame is a sync byte followed by four big-endian price bytes. The block assembles each frame into a 32-bit word and presents it to `computation_controller` as `stock_price`, qualified by a one-cycle `data_ready` pulse. Malformed or stalled frames are dropped and flagged, so that the downstream stage only ever sees complete prices.

## Interface

**Parameters**
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 1000: maximum idle cycles allowed between bytes inside a frame (minimum legal value 2).

**Ports**
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `n_rst`, input, 1: reset, asynchronous, active-low.
- `rx_byte`, input, 8: incoming byte. Sampled only when `rx_valid` is high.
- `rx_valid`, input, 1: `rx_byte` is valid this cycle. One byte per cycle, no backpressure.
- `stock_price`, output, 32: last successfully received price. Held until the next good frame.
- `data_ready`, output, 1: one-cycle pulse; `stock_price` is new this cycle.
- `frame_error`, output, 1: one-cycle pulse; a frame was aborted (timeout or checksum).
- `busy`, output, 1: high while a frame is in progress (any state except IDLE).

## Operation

- **States:** IDLE, B3, B2, B1, B0, CHK (present only with the macro), EMIT.
- **IDLE:**
  - `rx_valid` with `rx_byte == SYNC_BYTE` -> B3.
  - Any other byte is discarded silently; no error is raised.
- **B3 to B0:**
  - Each accepted byte is loaded into the shadow register: bits [31:24] in B3, [23:16] in B2, [15:8] in B1, [7:0] in B0.
  - A value equal to `SYNC_BYTE` in a data position is treated as data, not as a resync.
  - After B0 the FSM goes to CHK if the macro is defined, otherwise to EMIT.
- **EMIT:**
  - Copies the shadow register to `stock_price` and pulses `data_ready`.
  - Returns to IDLE on the next cycle.
  - A byte arriving in the EMIT cycle is evaluated as an IDLE byte, so back-to-back frames are supported.
- **Timeout:**
  - The idle counter clears on every accepted byte and increments on each cycle without `rx_valid` while in B3..CHK.
  - When the counter reaches `TIMEOUT_CYCLES` and `rx_valid` is low in that cycle, the frame is aborted: `frame_error` pulses and the FSM goes to IDLE.
  - If `rx_valid` is high in that same cycle, the byte is accepted; the byte wins over the timeout.
- **Shadow register:** `stock_price` is never altered by a partial or aborted frame.
- **Reset mid-frame:** immediately returns to IDLE and clears all registers.

## Timing

- **Reset values:** `stock_price` = 0, `data_ready` = 0, `frame_error` = 0, `busy` = 0, state = IDLE, idle counter = 0.
- **Latency without the macro:**
  - The last price byte is accepted at cycle N.
  - `data_ready` is high and `stock_price` is valid at cycle N+1.
- **Latency with the macro:** the checksum byte is accepted at cycle N; `data_ready` or `frame_error` at cycle N+1.
- **Pulse width:** `data_ready` and `frame_error` are registered, never high together, and each lasts exactly one cycle.
- **`busy`:**
  - Rises the cycle after the sync byte is accepted.
  - Falls in the cycle after EMIT or after an abort.
- **Downstream requirement:** `computation_controller` must sample `stock_price` in the cycle `data_ready` is high. The value remains stable afterward regardless.

## Configuration

- **`PRICE_RX_CHECKSUM_EN` defined:**
  - The frame carries a fifth byte equal to the XOR of the four price bytes.
  - CHK waits for that byte, under the same timeout rule as the price bytes.
  - Match -> EMIT. Mismatch -> `frame_error` pulse, return to IDLE, and `stock_price` is unchanged.
- **Undefined:** no CHK state; the frame is sync + 4 bytes, and no checksum logic is synthesized.

## Structure

- **Shared package `computation_pkg`:**
  - `rx_state_t` enum (4-bit encoding).
  - `DEFAULT_SYNC_BYTE` = 8'hA5.
  - `PRICE_W` = 32.
  - `computation_controller` imports the same `PRICE_W`.
- **Sub-module `rx_timeout_counter`:**
  - Width derived from `TIMEOUT_CYCLES` via `$clog2`.
  - Inputs: clear, count enable.
  - Output: `expired` flag.
- **`price_receiver`:** contains the FSM, the shadow register, the checksum accumulator and the output registers.

## Test plan

- **Good frame:** send A5,12,34,56,78 back-to-back -> `stock_price` = 32'h12345678 with a one-cycle `data_ready` the cycle after 78 (with the macro, append checksum 08).
- **Garbage in IDLE, then back-to-back frames:** 00,FF,A5,00,00,00,01 then immediately A5,00,00,00,02 -> two `data_ready` pulses with values 1 then 2, and no `frame_error`.
- **Timeout:** with `TIMEOUT_CYCLES` = 4, send A5,11 then 4 idle cycles -> `frame_error` pulse, `stock_price` keeps its previous value. A byte sent exactly on the expiry cycle -> accepted, no error.
- **Sync value as data:** A5,A5,A5,A5,A5 -> `stock_price` = 32'hA5A5A5A5.
- **Checksum mismatch (macro on):** A5,12,34,56,78,09 -> `frame_error`, no `data_ready`, `stock_price` unchanged.
- **Reset mid-frame:** after A5,12 assert `n_rst` low asynchronously -> all outputs 0 immediately. After release, a complete frame is received normally.
